// File: rtl/ex_mul_unit.sv
// ex_mul_unit: multi-cycle radix-2 Booth multiplier for the EX stage.
// It holds the ID/EX register (stall) while a MULT iterates and pulses done with the product.
// Optional feature macro: MUL_UNSIGNED_EN adds MULTU (zero-extended operands, 33 iterations).
module ex_mul_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [5:0]  funct,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd_in,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] result_hi,
    output logic [31:0] result_lo,
    output logic [4:0]  rd_out
);
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] LAST_SIGNED = 6'd31;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [5:0]  count;
    logic [32:0] reg_a;
    logic [32:0] reg_q;
    logic [32:0] reg_m;
    logic        q_1;
    logic        is_mul;
    logic        accept;
    logic        last_iter;
    logic [32:0] ext_a;
    logic [32:0] ext_b;
    logic [33:0] sum;
    logic [32:0] a_step;
    logic [32:0] q_step;
    logic [63:0] product;

`ifdef MUL_UNSIGNED_EN
    localparam logic [5:0] FUNCT_MULTU   = 6'h19;
    localparam logic [5:0] LAST_UNSIGNED = 6'd32;

    logic req_unsigned;
    logic op_unsigned;

    // Decode MULT/MULTU; MULTU zero-extends and runs one extra iteration over the 33-bit multiplier
    always_comb begin
        req_unsigned = (funct == FUNCT_MULTU);
        is_mul       = (funct == FUNCT_MULT) || req_unsigned;
        ext_a        = req_unsigned ? {1'b0, op_a} : {op_a[31], op_a};
        ext_b        = req_unsigned ? {1'b0, op_b} : {op_b[31], op_b};
        last_iter    = (count == (op_unsigned ? LAST_UNSIGNED : LAST_SIGNED));
        product      = op_unsigned ? {a_step[30:0], q_step}
                                   : {a_step[31:0], q_step[32:1]};
    end

    // Remember the signedness of the accepted operation so funct may change while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_unsigned <= 1'b0;
        end else if (accept) begin
            op_unsigned <= req_unsigned;
        end
    end
`else
    // Decode MULT only; after 32 steps the top multiplier bit still sits in q[0], so the product is one bit up
    always_comb begin
        is_mul    = (funct == FUNCT_MULT);
        ext_a     = {op_a[31], op_a};
        ext_b     = {op_b[31], op_b};
        last_iter = (count == LAST_SIGNED);
        product   = {a_step[31:0], q_step[32:1]};
    end
`endif

    assign accept = rst_n && (state == S_IDLE) && valid_in && !flush && is_mul;
    assign busy   = (state != S_IDLE);

    // One Booth step: add/subtract M by {q[0],q_1}, then arithmetic right shift of {A,Q,Q_1}
    always_comb begin
        sum = {reg_a[32], reg_a};
        case ({reg_q[0], q_1})
            2'b01:   sum = {reg_a[32], reg_a} + {reg_m[32], reg_m};
            2'b10:   sum = {reg_a[32], reg_a} - {reg_m[32], reg_m};
            default: sum = {reg_a[32], reg_a};
        endcase
        a_step = sum[33:1];
        q_step = {sum[0], reg_q[32:1]};
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; flush aborts RUN/DONE and masks the done pulse
    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                stall = 1'b1;
                if (flush) begin
                    state_nxt = S_IDLE;
                end else if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = !flush;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: load on acceptance, iterate in RUN, capture the product on the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 6'd0;
            reg_a     <= 33'd0;
            reg_q     <= 33'd0;
            reg_m     <= 33'd0;
            q_1       <= 1'b0;
            result_hi <= 32'd0;
            result_lo <= 32'd0;
            rd_out    <= 5'd0;
        end else if (accept) begin
            count  <= 6'd0;
            reg_a  <= 33'd0;
            q_1    <= 1'b0;
            reg_m  <= ext_a;
            reg_q  <= ext_b;
            rd_out <= rd_in;
        end else if (state == S_RUN) begin
            count <= count + 6'd1;
            reg_a <= a_step;
            reg_q <= q_step;
            q_1   <= reg_q[0];
            if (last_iter && !flush) begin
                result_hi <= product[63:32];
                result_lo <= product[31:0];
            end
        end
    end
endmodule

// File: tb/tb_ex_mul_unit.sv
// tb_ex_mul_unit: directed self-checking bench for ex_mul_unit.
module tb_ex_mul_unit;
    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [5:0]  funct;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
    logic [4:0]  rd_out;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    ex_mul_unit dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .funct(funct),
        .op_a(op_a), .op_b(op_b), .rd_in(rd_in), .flush(flush),
        .stall(stall), .busy(busy), .done(done),
        .result_hi(result_hi), .result_lo(result_lo), .rd_out(rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle count used to time done pulses
    always @(posedge clk) cyc <= cyc + 1;

    // Drive one request in the current cycle and measure: edges until done, stalled cycles, cycle of done
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                          input logic [4:0] rd, input bit scramble,
                          output int lat, output int stall_cycles, output int done_cyc);
        valid_in = 1'b1; funct = f; op_a = a; op_b = b; rd_in = rd; flush = 1'b0;
        #1;
        stall_cycles = (stall === 1'b1) ? 1 : 0;
        lat = -1;
        done_cyc = -1;
        for (int k = 1; k <= 45 && lat < 0; k++) begin
            @(posedge clk); #1;
            if (scramble) begin
                valid_in = 1'b1;
                funct    = k[0] ? 6'h19 : 6'h18;
                op_a     = 32'hDEAD0000 + k;
                op_b     = ~op_a;
                rd_in    = 5'd31 - rd;
            end else begin
                valid_in = 1'b0;
            end
            #1;
            if (done === 1'b1) begin
                lat = k;
                done_cyc = cyc;
            end else if (stall === 1'b1) begin
                stall_cycles++;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; valid_in = 1'b0; funct = 6'h0; op_a = 0; op_b = 0; rd_in = 0; flush = 1'b0;
        #1 rst_n = 1'b0;
        valid_in = 1'b1; funct = 6'h18; op_a = 32'h1234; op_b = 32'h5678; rd_in = 5'd3;
        @(posedge clk); @(posedge clk); #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        compared++; if (result_hi !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_hi: got %h want 0", result_hi); end
        compared++; if (result_lo !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_lo: got %h want 0", result_lo); end
        compared++; if (rd_out !== 5'h0) begin mismatched++; $display("[TB] FAIL reset_rd: got %h want 0", rd_out); end
    endtask

    task automatic test_mult_basic();
        int lat, sc, dc;
        rst_n = 1'b1;
        run_op(32'd3, 32'hFFFFFFFC, 6'h18, 5'd9, 1'b0, lat, sc, dc);
        compared++; if (lat != 33) begin mismatched++; $display("[TB] FAIL basic_latency: got %0d want 33", lat); end
        compared++; if (sc != 33) begin mismatched++; $display("[TB] FAIL basic_stall_cycles: got %0d want 33", sc); end
        compared++; if (result_hi !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL basic_hi: got %h want ffffffff", result_hi); end
        compared++; if (result_lo !== 32'hFFFFFFF4) begin mismatched++; $display("[TB] FAIL basic_lo: got %h want fffffff4", result_lo); end
        compared++; if (rd_out !== 5'd9) begin mismatched++; $display("[TB] FAIL basic_rd: got %0d want 9", rd_out); end
        compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_done_stall: got %b want 0", stall); end
    endtask

    task automatic test_mult_corner();
        int lat, sc, dc;
        logic [31:0] a_tab  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF};
        logic [31:0] hi_tab [3] = '{32'h40000000, 32'h00000000, 32'h3FFFFFFF};
        logic [31:0] lo_tab [3] = '{32'h00000000, 32'h00000001, 32'h00000001};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            run_op(a_tab[i], a_tab[i], 6'h18, 5'(i + 1), 1'b0, lat, sc, dc);
            compared++; if (lat != 33) begin mismatched++; $display("[TB] FAIL corner%0d_latency: got %0d want 33", i, lat); end
            compared++; if (result_hi !== hi_tab[i]) begin mismatched++; $display("[TB] FAIL corner%0d_hi: got %h want %h", i, result_hi, hi_tab[i]); end
            compared++; if (result_lo !== lo_tab[i]) begin mismatched++; $display("[TB] FAIL corner%0d_lo: got %h want %h", i, result_lo, lo_tab[i]); end
        end
    endtask

    task automatic test_flush();
        bit saw_done;
        @(posedge clk); #1;
        valid_in = 1'b1; funct = 6'h18; op_a = 32'd5; op_b = 32'd9; rd_in = 5'd4;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
        end
        flush = 1'b1;
        #1;
        compared++; if (stall !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_run_stall: got %b want 1", stall); end
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_busy: got %b want 0", busy); end
        compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_stall: got %b want 0", stall); end
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #2;
            if (done === 1'b1) saw_done = 1'b1;
        end
        compared++; if (saw_done) begin mismatched++; $display("[TB] FAIL flush_no_done: got done want none"); end
        compared++; if (result_hi !== 32'h3FFFFFFF) begin mismatched++; $display("[TB] FAIL flush_hold_hi: got %h want 3fffffff", result_hi); end
        compared++; if (result_lo !== 32'h00000001) begin mismatched++; $display("[TB] FAIL flush_hold_lo: got %h want 00000001", result_lo); end
    endtask

    task automatic test_reset_mid_run();
        bit saw_done;
        @(posedge clk); #1;
        valid_in = 1'b1; funct = 6'h18; op_a = 32'd11; op_b = 32'd13; rd_in = 5'd21;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            valid_in = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy: got %b want 0", busy); end
        compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_stall: got %b want 0", stall); end
        compared++; if (result_hi !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_hi: got %h want 0", result_hi); end
        compared++; if (result_lo !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_lo: got %h want 0", result_lo); end
        compared++; if (rd_out !== 5'h0) begin mismatched++; $display("[TB] FAIL midrst_rd: got %h want 0", rd_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #2;
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        compared++; if (saw_done) begin mismatched++; $display("[TB] FAIL midrst_no_done: got activity want idle"); end
    endtask

    task automatic test_passthrough();
        logic [5:0] codes [2] = '{6'h20, 6'h1A};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            valid_in = 1'b1; funct = codes[i]; op_a = 32'd7; op_b = 32'd7; rd_in = 5'd2;
            #1;
            compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL pass%0d_stall: got %b want 0", i, stall); end
            @(posedge clk); #2;
            compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL pass%0d_busy: got %b want 0", i, busy); end
        end
        funct = 6'h18; flush = 1'b1;
        #1;
        compared++; if (stall !== 1'b0) begin mismatched++; $display("[TB] FAIL flushacc_stall: got %b want 0", stall); end
        @(posedge clk); #2;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL flushacc_busy: got %b want 0", busy); end
        flush = 1'b0; valid_in = 1'b0;
    endtask

    task automatic test_multu();
        int lat, sc, dc;
        int exp_lat, exp_sc;
        logic [31:0] exp_hi, exp_lo;
`ifdef MUL_UNSIGNED_EN
        exp_lat = 34; exp_sc = 34; exp_hi = 32'hFFFFFFFE; exp_lo = 32'h00000001;
`else
        exp_lat = -1; exp_sc = 0; exp_hi = 32'h0; exp_lo = 32'h0;
`endif
        @(posedge clk); #1;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 6'h19, 5'd7, 1'b0, lat, sc, dc);
        compared++; if (lat != exp_lat) begin mismatched++; $display("[TB] FAIL multu_latency: got %0d want %0d", lat, exp_lat); end
        compared++; if (sc != exp_sc) begin mismatched++; $display("[TB] FAIL multu_stall_cycles: got %0d want %0d", sc, exp_sc); end
        compared++; if (result_hi !== exp_hi) begin mismatched++; $display("[TB] FAIL multu_hi: got %h want %h", result_hi, exp_hi); end
        compared++; if (result_lo !== exp_lo) begin mismatched++; $display("[TB] FAIL multu_lo: got %h want %h", result_lo, exp_lo); end
    endtask

    task automatic test_back_to_back();
        int lat1, sc1, dc1, lat2, sc2, dc2;
        @(posedge clk); #1;
        run_op(32'd7, 32'd6, 6'h18, 5'd11, 1'b1, lat1, sc1, dc1);
        compared++; if (lat1 != 33) begin mismatched++; $display("[TB] FAIL b2b_first_latency: got %0d want 33", lat1); end
        compared++; if (result_hi !== 32'h0) begin mismatched++; $display("[TB] FAIL b2b_first_hi: got %h want 0", result_hi); end
        compared++; if (result_lo !== 32'd42) begin mismatched++; $display("[TB] FAIL b2b_first_lo: got %h want 0000002a", result_lo); end
        compared++; if (rd_out !== 5'd11) begin mismatched++; $display("[TB] FAIL b2b_first_rd: got %0d want 11", rd_out); end
        @(posedge clk); #1;
        run_op(32'hFFFFFFFE, 32'd5, 6'h18, 5'd12, 1'b0, lat2, sc2, dc2);
        compared++; if (lat2 != 33) begin mismatched++; $display("[TB] FAIL b2b_second_latency: got %0d want 33", lat2); end
        compared++; if (result_hi !== 32'hFFFFFFFF) begin mismatched++; $display("[TB] FAIL b2b_second_hi: got %h want ffffffff", result_hi); end
        compared++; if (result_lo !== 32'hFFFFFFF6) begin mismatched++; $display("[TB] FAIL b2b_second_lo: got %h want fffffff6", result_lo); end
        compared++; if (rd_out !== 5'd12) begin mismatched++; $display("[TB] FAIL b2b_second_rd: got %0d want 12", rd_out); end
        compared++; if (dc2 - dc1 != 34) begin mismatched++; $display("[TB] FAIL b2b_done_spacing: got %0d want 34", dc2 - dc1); end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_mult_basic();
        test_mult_corner();
        test_flush();
        test_reset_mid_run();
        test_passthrough();
        test_multu();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
